// File: rtl/gate_truth_table_checker.sv
// Drives a 2-input gate through all four {a,b} vectors and checks y against EXP_TABLE.
// Build option: define STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module gate_truth_table_checker #(
  parameter logic [3:0] EXP_TABLE     = 4'b0111,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [2:0]       err_nxt;
  logic [3:0]       mask_nxt;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_cnt   <= err_nxt;
      fail_mask <= mask_nxt;
    end
  end

  // y is only looked at in SAMPLE, one or more cycles after a/b last moved.
  assign mismatch = (y != EXP_TABLE[idx]);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    a_nxt     = a;
    b_nxt     = b;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_cnt;
    mask_nxt  = fail_mask;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = 3'd0;
          mask_nxt  = 4'd0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          mask_nxt[idx] = 1'b1;
          err_nxt       = err_cnt + 3'd1;
        end
`ifdef STOP_ON_FAIL_EN
        if (mismatch || idx == 2'd3) begin
`else
        if (idx == 2'd3) begin
`endif
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == 3'd0);
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
        end else begin
          idx_nxt        = idx + 2'd1;
          {a_nxt, b_nxt} = idx + 2'd1;
          cnt_nxt        = '0;
          state_nxt      = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: two instances (default and 1-cycle settle / AND table)
// driven against bench-side gate models, checked every cycle against a run-level model.
module tb_gate_truth_table_checker;

  localparam int         S0 = 2;
  localparam int         S1 = 1;
  localparam logic [3:0] E0 = 4'b0111;
  localparam logic [3:0] E1 = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] start = 2'b00;
  int         mode [2];
  logic [1:0] a_w, b_w, y_w, busy_w, done_w, pass_w;
  logic [2:0] err_w [2];
  logic [3:0] mask_w [2];

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // mode: 0 NAND, 1 tied low, 2 NOR, 3 AND
  function automatic logic gate(int m, logic av, logic bv);
    case (m)
      0: return ~(av & bv);
      1: return 1'b0;
      2: return ~(av | bv);
      3: return av & bv;
      default: return 1'b0;
    endcase
  endfunction

  assign y_w[0] = gate(mode[0], a_w[0], b_w[0]);
  assign y_w[1] = gate(mode[1], a_w[1], b_w[1]);

  gate_truth_table_checker #(.EXP_TABLE(E0), .SETTLE_CYCLES(S0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_w[0]), .b(b_w[0]), .y(y_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]),
    .fail_mask(mask_w[0]));

  gate_truth_table_checker #(.EXP_TABLE(E1), .SETTLE_CYCLES(S1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_w[1]), .b(b_w[1]), .y(y_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]),
    .fail_mask(mask_w[1]));

  task automatic check(string name, int u, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (unit %0d): got %0d, expected %0d at %0t", name, u, act, exp, $time);
    end
  endtask

  // Run-level model: outcome of a whole run is predicted when it starts.
  int         scyc [2];
  logic [3:0] expt [2];
  bit         m_run [2];
  int         m_off [2];
  int         m_total [2];
  logic       m_done [2], m_pass [2];
  logic [1:0] m_ab [2];
  logic [2:0] m_err [2], m_fin_err [2];
  logic [3:0] m_mask [2], m_fin_mask [2];

  initial begin
    scyc[0] = S0; scyc[1] = S1;
    expt[0] = E0; expt[1] = E1;
  end

  task automatic predict(int u);
    int   n_vec;
    int   e;
    logic [3:0] mk;
    logic yv;
    n_vec = 4;
    e = 0;
    mk = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (n_vec == 4) begin
        yv = gate(mode[u], i[1], i[0]);
        if (yv != expt[u][i]) begin
          e++;
          mk[i] = 1'b1;
`ifdef STOP_ON_FAIL_EN
          n_vec = i + 1;
`endif
        end
      end
    end
    m_total[u]    = n_vec * (scyc[u] + 1);
    m_fin_err[u]  = 3'(e);
    m_fin_mask[u] = mk;
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_run[u] = 1'b0; m_off[u] = 0; m_done[u] = 1'b0; m_pass[u] = 1'b0;
        m_ab[u] = 2'd0; m_err[u] = 3'd0; m_mask[u] = 4'd0;
      end else if (start[u] && !m_run[u]) begin
        predict(u);
        m_run[u] = 1'b1; m_off[u] = 0; m_done[u] = 1'b0; m_pass[u] = 1'b0;
        m_ab[u] = 2'd0; m_err[u] = 3'd0; m_mask[u] = 4'd0;
      end else if (m_run[u]) begin
        m_off[u]++;
        if (m_off[u] == m_total[u]) begin
          m_run[u] = 1'b0; m_done[u] = 1'b1; m_ab[u] = 2'd0;
          m_err[u] = m_fin_err[u]; m_mask[u] = m_fin_mask[u];
          m_pass[u] = (m_fin_err[u] == 3'd0);
        end else begin
          m_ab[u] = 2'(m_off[u] / (scyc[u] + 1));
        end
      end
    end
  end

  // Compare every cycle; results are only meaningful outside a run.
  always @(negedge clk) begin
    if (m_done[0] !== 1'bx) begin
      for (int u = 0; u < 2; u++) begin
        check("a", u, a_w[u], m_ab[u][1]);
        check("b", u, b_w[u], m_ab[u][0]);
        check("busy", u, busy_w[u], m_run[u]);
        check("done", u, done_w[u], m_done[u]);
        if (!m_run[u]) begin
          check("pass", u, pass_w[u], m_pass[u]);
          check("err_cnt", u, err_w[u], m_err[u]);
          check("fail_mask", u, mask_w[u], m_mask[u]);
        end
      end
    end
  end

  task automatic run_check(int u, int restart, int exp_lat, logic exp_pass,
                           logic [2:0] exp_err, logic [3:0] exp_mask);
    int n;
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    #1;
    start[u] = 1'b0;
    check("start_busy", u, busy_w[u], 1);
    check("start_clear_done", u, done_w[u], 0);
    check("start_clear_err", u, err_w[u], 0);
    check("start_clear_mask", u, mask_w[u], 0);
    n = 0;
    while (!done_w[u] && n < 200) begin
      start[u] = (n + 1 == restart);
      @(posedge clk);
      #1;
      n++;
    end
    start[u] = 1'b0;
    check("done_latency", u, n, exp_lat);
    check("final_pass", u, pass_w[u], exp_pass);
    check("final_err_cnt", u, err_w[u], exp_err);
    check("final_fail_mask", u, mask_w[u], exp_mask);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    mode[0] = 0;
    mode[1] = 3;
    #1 rst_n = 1'b0;
    #20;
    check("reset_a", 0, a_w[0], 0);
    check("reset_busy", 0, busy_w[0], 0);
    check("reset_done", 0, done_w[0], 0);
    check("reset_pass", 0, pass_w[0], 0);
    check("reset_err", 0, err_w[0], 0);
    check("reset_mask", 0, mask_w[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // NAND gate against NAND table
    run_check(0, 0, 12, 1'b1, 3'd0, 4'b0000);
    // y stuck low
    mode[0] = 1;
`ifdef STOP_ON_FAIL_EN
    run_check(0, 0, 3, 1'b0, 3'd1, 4'b0001);
`else
    run_check(0, 0, 12, 1'b0, 3'd3, 4'b0111);
`endif
    // NOR gate against NAND table
    mode[0] = 2;
`ifdef STOP_ON_FAIL_EN
    run_check(0, 0, 6, 1'b0, 3'd1, 4'b0010);
`else
    run_check(0, 0, 12, 1'b0, 3'd2, 4'b0110);
`endif
    // start re-pulsed mid-run is ignored
    mode[0] = 0;
    run_check(0, 5, 12, 1'b1, 3'd0, 4'b0000);

    // reset during vector 2
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("vec2_a", 0, a_w[0], 1);
    check("vec2_b", 0, b_w[0], 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_a", 0, a_w[0], 0);
    check("async_rst_busy", 0, busy_w[0], 0);
    check("async_rst_done", 0, done_w[0], 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_check(0, 0, 12, 1'b1, 3'd0, 4'b0000);

    // one-cycle settle, AND table
    run_check(1, 0, 8, 1'b1, 3'd0, 4'b0000);
    mode[1] = 0;
`ifdef STOP_ON_FAIL_EN
    run_check(1, 0, 2, 1'b0, 3'd1, 4'b0001);
`else
    run_check(1, 0, 8, 1'b0, 3'd4, 4'b1111);
`endif
    mode[1] = 1;
    run_check(1, 0, 8, 1'b0, 3'd1, 4'b1000);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Hardware counterpart of the team's 2-input gate benches. The bench drives a/b and only prints y; this block drives the gate under test itself and checks its y.
- On start it steps a/b through all four input vectors, waits a settle interval, samples y and compares it with a parameterised expected truth table.
- Reports pass/fail, a mismatch count and a per-vector fail mask. Sits beside any gates_using_nand style combinational unit for on-board or regression self-test.

Parameters:
- EXP_TABLE, 4'b0111, expected y per vector index i = {a,b}; bit i is the expected y (default = NAND).
- SETTLE_CYCLES, 2, cycles a/b are held stable before y is sampled; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of the settle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a check run; sampled only in IDLE or DONE.
- a  output  1  stimulus to gate under test (registered).
- b  output  1  stimulus to gate under test (registered).
- y  input  1  response from gate under test.
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE; held until the next start or reset.
- pass  output  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  output  3  number of mismatching vectors, 0..4.
- fail_mask  output  4  bit i set when vector i mismatched.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=0, state=IDLE, idx=0, cnt=0. All outputs are registered.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: a=b=0. When start=1 at edge k:
  - idx<=0, {a,b}<=2'b00, cnt<=0;
  - err_cnt and fail_mask cleared;
  - busy<=1, done<=0, pass<=0;
  - next state SETTLE.
- SETTLE: cnt increments every edge. At the edge where cnt==SETTLE_CYCLES-1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE: lasts one cycle. At its edge, y is compared with EXP_TABLE[idx].
  - Mismatch: fail_mask[idx]<=1, err_cnt<=err_cnt+1.
  - If idx==3: go to DONE; busy<=0, done<=1, pass<=(final err_cnt==0), a=b=0.
  - Otherwise: idx<=idx+1, {a,b}<=idx+1, cnt<=0, go to SETTLE.
- Latency: each vector takes SETTLE_CYCLES+1 cycles, so done rises at edge k+4*(SETTLE_CYCLES+1). With defaults that is k+12.
- DONE: done, pass, err_cnt and fail_mask are held. start=1 restarts exactly as from IDLE, with the same-edge clear.
- start during SETTLE or SAMPLE is ignored, with no effect on the run.
- a/b change only on the edge that enters SETTLE. y is never sampled in the same cycle a/b change.
- err_cnt cannot exceed 4, so no wrap-around is possible.
- rst_n low at any time, including mid-run, immediately forces all reset values and aborts the run. There is no partial result.
- y is compared with a 2-state equality. The bench must drive a known value.

Optional Feature:
- Macro: STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE ends the run on that same edge.
  - Record fail_mask[idx] and err_cnt=1, go to DONE with pass=0.
  - Untested vectors keep fail_mask bits at 0.
- Undefined: all four vectors are always checked, as described above.

Test Plan:
- NAND model on y, defaults, start pulse at edge k -> a/b sequence 00,01,10,11, each held 3 cycles; done=1 at k+12; pass=1, err_cnt=0, fail_mask=4'b0000.
- y tied 0, defaults -> done at k+12, pass=0, err_cnt=3, fail_mask=4'b0111. With STOP_ON_FAIL_EN: done at k+3, err_cnt=1, fail_mask=4'b0001.
- NOR model with EXP_TABLE=4'b0111 -> vectors 1 and 2 mismatch; err_cnt=2, fail_mask=4'b0110, pass=0. AND model with EXP_TABLE=4'b1000 -> pass=1.
- start pulsed again at k+5 (mid-run) -> ignored, done still at k+12 with unchanged results. start in DONE -> results cleared the same edge, new run completes at +12.
- rst_n low for 1 cycle during vector 2 -> all outputs 0 asynchronously, state IDLE. Following start -> full 12-cycle run from vector 0.
- SETTLE_CYCLES=1 -> each vector held 2 cycles; done at k+8.
